// File: rtl/wb_line_responder.sv
// Wishbone pipelined responder serving 4-beat line fills and flushes from an
// internal word-wide RAM. Only beat 0 of a line carries an address; later
// beats walk the line sequentially and wrap within it.
// Optional feature: define WB_RESP_ERR_EN to add wb_err_o. With it, a line whose
// address has bits set above the RAM range answers with err instead of ack.
module wb_line_responder #(
  parameter int AWIDTH     = 27,
  parameter int DWIDTH     = 32,
  parameter int ROWWIDTH   = 4,
  parameter int MEM_AWIDTH = 12,
  parameter int RD_WAIT    = 2,
  parameter int WR_WAIT    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [AWIDTH-1:0]     wb_adr_i,
  input  logic [DWIDTH/8-1:0]   wb_sel_i,
  input  logic [DWIDTH-1:0]     wb_dat_i,
  output logic [DWIDTH-1:0]     wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_stall_o
`ifdef WB_RESP_ERR_EN
  ,
  output logic                  wb_err_o
`endif
);

  localparam int NB     = DWIDTH / 8;
  localparam int BB     = $clog2(NB);
  localparam int WB     = $clog2(ROWWIDTH);
  localparam int LW     = MEM_AWIDTH - WB;
  localparam int HI_LSB = BB + MEM_AWIDTH;
  localparam int DEPTH  = 2 ** MEM_AWIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [1:0]        state_q,   state_d;
  logic [WB-1:0]     beat_q,    beat_d;
  logic [WB-1:0]     offset_q,  offset_d;
  logic [LW-1:0]     line_q,    line_d;
  logic              oor_q,     oor_d;
  logic [3:0]        waitcnt_q, waitcnt_d;
  logic              we_q,      we_d;
  logic [DWIDTH-1:0] dat_q,     dat_d;
  logic              rd_fetch;
  logic              mem_wr;
  logic              adr_oor;
  logic              unused_adr;

  logic [DWIDTH-1:0] mem_q [DEPTH];

  // Out-of-range detection: only meaningful when the error response is built in;
  // otherwise the upper address bits simply alias into the RAM.
`ifdef WB_RESP_ERR_EN
  assign adr_oor    = |wb_adr_i[AWIDTH-1:HI_LSB];
  assign unused_adr = ^wb_adr_i[BB-1:0];
`else
  assign adr_oor    = 1'b0;
  assign unused_adr = ^{wb_adr_i[AWIDTH-1:HI_LSB], wb_adr_i[BB-1:0]};
`endif

  // Next-state logic for the beat FSM, line/offset tracking and read data capture.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    beat_d    = beat_q;
    offset_d  = offset_q;
    line_d    = line_q;
    oor_d     = oor_q;
    waitcnt_d = waitcnt_q;
    we_d      = we_q;
    dat_d     = dat_q;
    rd_fetch  = 1'b0;
    mem_wr    = 1'b0;

    if (!wb_cyc_i) begin
      // Dropping cyc abandons the burst wherever it is; the next line restarts at beat 0.
      state_d = ST_IDLE;
      beat_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wb_stb_i) begin
            we_d      = wb_we_i;
            waitcnt_d = wb_we_i ? 4'(WR_WAIT) : 4'(RD_WAIT);
            if (beat_q == '0) begin
              line_d   = wb_adr_i[BB+MEM_AWIDTH-1:BB+WB];
              offset_d = wb_adr_i[BB+WB-1:BB];
              oor_d    = adr_oor;
            end
            if (waitcnt_d == 4'd0) begin
              state_d  = ST_ACK;
              rd_fetch = !wb_we_i;
            end else begin
              state_d  = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          waitcnt_d = waitcnt_q - 4'd1;
          if (waitcnt_q == 4'd1) begin
            state_d  = ST_ACK;
            rd_fetch = !we_q;
          end
        end
        ST_ACK: begin
          mem_wr   = we_q && !oor_q;
          beat_d   = beat_q + WB'(1);
          offset_d = offset_q + WB'(1);
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Read data is captured one edge before the ack so it is valid in the ack cycle.
    if (rd_fetch && !oor_d) begin
      dat_d = mem_q[{line_d, offset_d}];
    end
  end

  // Control and data registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    if (rst_i) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      offset_q  <= '0;
      line_q    <= '0;
      oor_q     <= 1'b0;
      waitcnt_q <= '0;
      we_q      <= 1'b0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      offset_q  <= offset_d;
      line_q    <= line_d;
      oor_q     <= oor_d;
      waitcnt_q <= waitcnt_d;
      we_q      <= we_d;
      dat_q     <= dat_d;
    end
  end

  // Byte-lane write into the backing RAM at the ack edge.
  always_ff @(posedge clk_i) begin
    // NOTE: the RAM has no reset; its contents survive rst_i so it maps onto block RAM.
    if (mem_wr && !rst_i) begin
      for (int b = 0; b < NB; b++) begin
        if (wb_sel_i[b]) begin
          mem_q[{line_q, offset_q}][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
        end
      end
    end
  end

  assign wb_dat_o   = dat_q;
  assign wb_stall_o = (state_q == ST_WAIT);
  assign wb_ack_o   = (state_q == ST_ACK) && wb_cyc_i && !oor_q;
`ifdef WB_RESP_ERR_EN
  assign wb_err_o   = (state_q == ST_ACK) && wb_cyc_i && oor_q;
`endif

endmodule
